// File: rtl/arith_coding_pkg.sv
// rtl/arith_coding_pkg.sv - shared types, defaults and code-length helpers for the arithmetic-coding datapath
// Contents: seq_state_e {IDLE, SHIFT}; DEF_SYM_W / DEF_MAX_UNARY / DEF_CODE_W defaults;
//           code_width() and code_len() helpers.
package arith_coding_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_e;

    localparam int DEF_SYM_W     = 4;
    localparam int DEF_MAX_UNARY = 3;

    // Longest codeword: escape prefix (max_unary+1 ones) plus the raw symbol bits.
    function automatic int code_width(input int max_unary, input int sym_w);
        return max_unary + 1 + sym_w;
    endfunction

    localparam int DEF_CODE_W = code_width(DEF_MAX_UNARY, DEF_SYM_W);

    function automatic int code_len(input int sym, input int max_unary, input int sym_w);
        return (sym <= max_unary) ? sym + 1 : code_width(max_unary, sym_w);
    endfunction

endpackage

// File: rtl/unary_codeword_gen.sv
// rtl/unary_codeword_gen.sv - combinational symbol to left-aligned unary/escape codeword mapper
// Ports: sym (in, SYM_W) symbol value; codeword (out, CODE_W) MSB-first code, left-aligned;
//        length (out, LEN_W) number of valid code bits; is_escape (out) symbol exceeds MAX_UNARY.
module unary_codeword_gen
    import arith_coding_pkg::*;
#(
    parameter int SYM_W     = DEF_SYM_W,
    parameter int MAX_UNARY = DEF_MAX_UNARY,
    parameter int CODE_W    = code_width(MAX_UNARY, SYM_W),
    parameter int LEN_W     = $clog2(CODE_W) + 1
) (
    input  logic [SYM_W-1:0]  sym,
    output logic [CODE_W-1:0] codeword,
    output logic [LEN_W-1:0]  length,
    output logic              is_escape
);

    always_comb begin
        is_escape = (int'(sym) > MAX_UNARY);
        codeword  = '0;
        if (is_escape) begin
            // Escape prefix fills the top MAX_UNARY+1 bits; raw symbol fills the rest exactly.
            codeword = {{(MAX_UNARY + 1){1'b1}}, sym};
        end else begin
            // s leading ones; the terminating zero is already present below them.
            for (int i = 0; i < CODE_W; i++) begin
                if (i < int'(sym)) begin
                    codeword[CODE_W-1-i] = 1'b1;
                end
            end
        end
        length = LEN_W'(code_len(int'(sym), MAX_UNARY, SYM_W));
    end

endmodule

// File: rtl/symbol_code_sequencer.sv
// rtl/symbol_code_sequencer.sv - serialises unary/escape codewords of incoming symbols MSB-first
// Ports: sys_clk, sys_reset (sync, active-high);
//        sym_in/sym_valid/sym_last/sym_ready - symbol input handshake;
//        bit_out/bit_valid/bit_last/bit_ready - serial code bit output handshake;
//        busy - codeword in flight; sym_count/esc_count - saturating statistics.
module symbol_code_sequencer
    import arith_coding_pkg::*;
#(
    parameter int SYM_W     = DEF_SYM_W,
    parameter int MAX_UNARY = DEF_MAX_UNARY,
    parameter int CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    input  logic             sym_last,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    input  logic             bit_ready,
    output logic             busy,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] esc_count
);

    localparam int CW    = code_width(MAX_UNARY, SYM_W);
    localparam int LEN_W = $clog2(CW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_e        state;
    logic [CW-1:0]     shift_reg;
    logic [LEN_W-1:0]  bit_cnt;
    logic              last_flag;

    logic [CW-1:0]     gen_code;
    logic [LEN_W-1:0]  gen_len;
    logic              gen_esc;

    unary_codeword_gen #(
        .SYM_W     (SYM_W),
        .MAX_UNARY (MAX_UNARY),
        .CODE_W    (CW),
        .LEN_W     (LEN_W)
    ) u_gen (
        .sym       (sym_in),
        .codeword  (gen_code),
        .length    (gen_len),
        .is_escape (gen_esc)
    );

    // The shift register MSB is the current bit; it is cleared whenever idle so bit_out reads 0.
    assign bit_out = shift_reg[CW-1];

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            last_flag <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
            sym_ready <= 1'b1;
            sym_count <= '0;
            esc_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sym_valid && sym_ready) begin
                        shift_reg <= gen_code;
                        bit_cnt   <= gen_len;
                        last_flag <= sym_last;
                        bit_valid <= 1'b1;
                        bit_last  <= sym_last && (gen_len == LEN_W'(1));
                        busy      <= 1'b1;
                        sym_ready <= 1'b0;
                        state     <= SHIFT;
                        if (sym_count != CNT_MAX) begin
                            sym_count <= sym_count + 1'b1;
                        end
                        if (gen_esc && (esc_count != CNT_MAX)) begin
                            esc_count <= esc_count + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        if (bit_cnt == LEN_W'(1)) begin
                            state     <= IDLE;
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            last_flag <= 1'b0;
                            bit_valid <= 1'b0;
                            bit_last  <= 1'b0;
                            busy      <= 1'b0;
                            sym_ready <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[CW-2:0], 1'b0};
                            bit_cnt   <= bit_cnt - 1'b1;
                            // Next bit is the final one when two remain before this shift.
                            bit_last  <= last_flag && (bit_cnt == LEN_W'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_code_sequencer.sv
// tb/tb_symbol_code_sequencer.sv - self-checking bench for symbol_code_sequencer
module tb_symbol_code_sequencer;

    localparam int SYM_W     = 4;
    localparam int MAX_UNARY = 3;

    logic             clk = 1'b0;
    logic             sys_reset = 1'b1;
    logic [SYM_W-1:0] sym_in = '0;
    logic             sym_valid = 1'b0;
    logic             sym_last = 1'b0;
    logic             bit_ready = 1'b0;

    logic        sym_ready, bit_out, bit_valid, bit_last, busy;
    logic [15:0] sym_count, esc_count;
    logic        sym_ready2, bit_out2, bit_valid2, bit_last2, busy2;
    logic [1:0]  sym_count2, esc_count2;

    int n_checks = 0;
    int n_pass   = 0;
    int sym_n    = 0;
    int esc_n    = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    symbol_code_sequencer #(.SYM_W(SYM_W), .MAX_UNARY(MAX_UNARY), .CNT_W(16)) dut (
        .sys_clk(clk), .sys_reset(sys_reset), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_last(sym_last), .sym_ready(sym_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(bit_ready), .busy(busy),
        .sym_count(sym_count), .esc_count(esc_count)
    );

    symbol_code_sequencer #(.SYM_W(SYM_W), .MAX_UNARY(MAX_UNARY), .CNT_W(2)) dut_sat (
        .sys_clk(clk), .sys_reset(sys_reset), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_last(sym_last), .sym_ready(sym_ready2), .bit_out(bit_out2), .bit_valid(bit_valid2),
        .bit_last(bit_last2), .bit_ready(bit_ready), .busy(busy2),
        .sym_count(sym_count2), .esc_count(esc_count2)
    );

    function automatic int sat(input int n, input int max_v);
        return (n > max_v) ? max_v : n;
    endfunction

    // Reference codeword: s ones + '0' for small symbols, else escape ones + raw bits MSB-first.
    function automatic void model_code(input int s);
        exp_bits.delete();
        if (s <= MAX_UNARY) begin
            repeat (s) exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b0);
        end else begin
            repeat (MAX_UNARY + 1) exp_bits.push_back(1'b1);
            for (int b = SYM_W - 1; b >= 0; b--) exp_bits.push_back(bit'((s >> b) & 1));
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        sys_reset = 1'b1;
        sym_valid = 1'b0;
        bit_ready = 1'b0;
        @(negedge clk);
        sys_reset = 1'b0;
        sym_n = 0;
        esc_n = 0;
    endtask

    // Sends one symbol and consumes its codeword, checking every observed bit cycle.
    task automatic run_symbol(input int s, input bit last, input bit random_bp,
                              input int first_stall, input bit expect_immediate);
        int  waits = 0;
        int  idx = 0;
        int  stalls = 0;
        int  stall_left = first_stall;
        bit  rdy;
        bit  exp_last;
        model_code(s);
        while (sym_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        n_checks++;
        if (sym_ready !== 1'b1) $display("FAIL sym_ready_wait: sym_ready=%b required 1", sym_ready);
        else n_pass++;
        if (expect_immediate) begin
            n_checks++;
            if (waits != 0) $display("FAIL idle_gap: waited %0d cycles required 0", waits);
            else n_pass++;
        end
        sym_in    = SYM_W'(s);
        sym_last  = last;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        sym_in    = SYM_W'($urandom);
        sym_last  = 1'($urandom);
        sym_n++;
        if (s > MAX_UNARY) esc_n++;
        while (idx < exp_bits.size() && stalls < 200) begin
            exp_last = last && (idx == exp_bits.size() - 1);
            n_checks++;
            if (bit_valid !== 1'b1 || bit_out !== exp_bits[idx] || bit_last !== exp_last ||
                sym_ready !== 1'b0 || busy !== 1'b1 || bit_out2 !== exp_bits[idx] ||
                bit_valid2 !== 1'b1 || bit_last2 !== exp_last || sym_ready2 !== 1'b0 || busy2 !== 1'b1)
                $display("FAIL bit sym=%0d idx=%0d: valid=%b out=%b last=%b rdy=%b busy=%b sat(out=%b valid=%b last=%b) required valid=1 out=%b last=%b rdy=0 busy=1",
                         s, idx, bit_valid, bit_out, bit_last, sym_ready, busy, bit_out2, bit_valid2, bit_last2,
                         exp_bits[idx], exp_last);
            else n_pass++;
            if (idx == 0 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bit_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            else stalls++;
        end
        bit_ready = 1'b0;
        n_checks++;
        if (idx != exp_bits.size()) $display("FAIL bit_timeout sym=%0d: consumed %0d required %0d", s, idx, exp_bits.size());
        else n_pass++;
        n_checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || sym_ready !== 1'b1 || bit_last !== 1'b0 || bit_out !== 1'b0)
            $display("FAIL end_idle sym=%0d: valid=%b busy=%b rdy=%b last=%b out=%b required 0,0,1,0,0",
                     s, bit_valid, busy, sym_ready, bit_last, bit_out);
        else n_pass++;
        n_checks++;
        if (sym_count !== 16'(sat(sym_n, 65535)) || esc_count !== 16'(sat(esc_n, 65535)) ||
            sym_count2 !== 2'(sat(sym_n, 3)) || esc_count2 !== 2'(sat(esc_n, 3)))
            $display("FAIL counters: sym=%0d esc=%0d sat_sym=%0d sat_esc=%0d required %0d %0d %0d %0d",
                     sym_count, esc_count, sym_count2, esc_count2, sym_n, esc_n, sat(sym_n, 3), sat(esc_n, 3));
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bit_out !== 1'b0 || bit_valid !== 1'b0 || bit_last !== 1'b0 || busy !== 1'b0 ||
            sym_ready !== 1'b1 || sym_count !== 16'd0 || esc_count !== 16'd0 ||
            sym_count2 !== 2'd0 || esc_count2 !== 2'd0)
            $display("FAIL reset_state: out=%b valid=%b last=%b busy=%b rdy=%b cnt=%0d esc=%0d required 0,0,0,0,1,0,0",
                     bit_out, bit_valid, bit_last, busy, sym_ready, sym_count, esc_count);
        else n_pass++;
    endtask

    task automatic test_single_unary();
        run_symbol(2, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_symbol(0, 1'b0, 1'b0, 0, 1'b0);
        run_symbol(3, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (sym_count !== 16'd2) $display("FAIL b2b_count: sym_count=%0d required 2", sym_count);
        else n_pass++;
    endtask

    task automatic test_escape();
        apply_reset();
        run_symbol(9, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (esc_count !== 16'd1) $display("FAIL escape_count: esc_count=%0d required 1", esc_count);
        else n_pass++;
    endtask

    task automatic test_backpressure_last();
        run_symbol(1, 1'b1, 1'b0, 5, 1'b0);
    endtask

    task automatic test_reset_mid_codeword();
        apply_reset();
        sym_in = 4'd5;
        sym_last = 1'b0;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        bit_ready = 1'b1;
        repeat (2) @(negedge clk);
        bit_ready = 1'b0;
        sys_reset = 1'b1;
        @(negedge clk);
        sys_reset = 1'b0;
        sym_n = 0;
        esc_n = 0;
        n_checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || sym_ready !== 1'b1 ||
            sym_count !== 16'd0 || esc_count !== 16'd0)
            $display("FAIL mid_reset: valid=%b busy=%b rdy=%b cnt=%0d esc=%0d required 0,0,1,0,0",
                     bit_valid, busy, sym_ready, sym_count, esc_count);
        else n_pass++;
        run_symbol(0, 1'b1, 1'b0, 0, 1'b1);
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (5) run_symbol(int'($urandom_range(MAX_UNARY + 1, 15)), 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (sym_count2 !== 2'd3 || esc_count2 !== 2'd3 || sym_count !== 16'd5 || esc_count !== 16'd5)
            $display("FAIL saturation: sat sym=%0d esc=%0d wide sym=%0d esc=%0d required 3 3 5 5",
                     sym_count2, esc_count2, sym_count, esc_count);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            run_symbol(int'($urandom_range(0, 15)), 1'($urandom), 1'b1, int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_unary();
        test_back_to_back();
        test_escape();
        test_backpressure_last();
        test_reset_mid_codeword();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
